ps2_scancode_rx: RTL
====================

Name: ps2_scancode_rx

Overview:
- Front-end PS/2 receiver that deserialises raw `ps2_clk`/`ps2_dat` from the IO controller.
- Checks framing and odd parity, and folds the E0/F0/E1 prefixes into complete key events.
- Buffers the events in a small FIFO behind a valid/ready port.
- Feeds the keyboard matrix mapper, so the mapper sees one clean event per key transition instead of raw bit-level PS/2.

Parameters:
- FILTER_LEN, 4: consecutive identical `ps2_clk` samples required before the filtered clock changes level (range 2..15).
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYC, 50000: idle clk cycles allowed between bit edges inside a frame (used only with PS2_RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_dat  in  1  raw PS/2 data, asynchronous.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_code  out  8  scancode at the FIFO head.
- ev_ext  out  1  head event was E0-prefixed.
- ev_release  out  1  head event was F0-prefixed (key released).
- err_parity  out  1  one-cycle pulse: frame discarded, parity wrong.
- err_frame  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  one-cycle pulse: event dropped, FIFO full.

Interface decision: one clock, `clk`; reset is `reset`, synchronous and active-high.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; FSM in IDLE.
  - Prefix flags and pause skip counter cleared.
  - Synchronisers and filter preset to 1 (idle bus).
- Input conditioning:
  - Both lines pass through a 2-FF synchroniser.
  - The filtered clock changes level only after FILTER_LEN equal synced samples.
  - A sample strobe fires in the cycle the filtered clock goes 1→0; `ps2_dat` (synced) is captured in that same cycle.
  - Glitches shorter than FILTER_LEN cycles are ignored.
- Frame FSM (advances on sample strobes only):
  - IDLE: strobe with dat=0 goes to DATA, bit counter=0. Strobe with dat=1 is ignored and the FSM stays in IDLE.
  - DATA: shift in LSB first; after the 8th bit go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: check both conditions, then return to IDLE:
    - If dat=0: pulse err_frame.
    - Else if XOR of data and parity is not 1: pulse err_parity.
    - Else: pass the byte to prefix logic.
  - Any error also clears the prefix flags and the skip counter.
- Prefix logic, per accepted byte:
  - If skip counter is non-zero: decrement it and drop the byte. When it reaches 0, push {ext=1, rel=0, code=8'h77} (Pause).
  - Else E0: set ext flag.
  - Else F0: set rel flag.
  - Else E1: load skip=7.
  - Else: push {ext flag, rel flag, byte}, then clear both flags.
  - Prefix bytes never produce events.
- Latency: the push is registered on the STOP strobe cycle. ev_valid is high the next cycle if the FIFO was empty.
- FIFO:
  - ev_* present the head whenever ev_valid=1; pop on ev_valid && ev_ready.
  - Events come out in arrival order.
  - Push while full and no pop: event dropped, overflow pulses 1 cycle, contents unchanged.
  - Push and pop in the same cycle while full: both succeed.
  - Push and pop in the same cycle while empty: not possible, because a push becomes visible only the next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth, plus an explicit count.
- Reset asserted mid-frame or mid-prefix sequence: the partial frame and any pending prefix are lost, and no event or error pulse is produced.

Optional Feature:
- PS2_RX_TIMEOUT_EN defined:
  - A counter runs whenever the FSM is not in IDLE and is cleared on every strobe.
  - Reaching TIMEOUT_CYC forces IDLE, clears the prefix flags and skip counter, and pulses err_frame.
- Not defined: no counter; a partial frame waits indefinitely for further edges.

Decomposition:
- Package `ps2_pkg` holds:
  - `ps2_ev_t` packed struct {ext, release, code[7:0]}, 10 bits.
  - Constants PS2_PFX_EXT=8'hE0, PS2_PFX_REL=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_PAUSE_CODE=8'h77, PS2_PAUSE_SKIP=7.
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
- One sub-module, `ps2_ev_fifo`: a parameterised synchronous FIFO of `ps2_ev_t` with valid/ready pop, push, full and overflow pulse.

Test Plan:
- Frame 0x1C, parity 0, stop 1 → ev_valid the cycle after the stop strobe; code=1C, ext=0, release=0; err_* stay 0.
- Frames E0,F0,74 → exactly one event {ext=1, release=1, code=74}; no events for the prefixes.
- Frame 0x29 with parity=1 → err_parity one pulse, no event. Then 0x29 with parity=0 → event code=29, ext=0.
- ev_ready=0, five frames 16,1E,26,25,2E, FIFO_DEPTH=4 → fifth drops and overflow pulses once. Raising ev_ready pops 16,1E,26,25 in order, then ev_valid=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → one event {ext=1, release=0, code=77}; a following 0x1C frame yields {0,0,1C}.
- Timeout and glitch (macro defined): start bit plus 3 data bits, then stall TIMEOUT_CYC cycles → err_frame pulse, FSM returns to IDLE, and the next full 0x1C frame decodes. Separately, a 2-cycle low glitch on ps2_clk with FILTER_LEN=4 produces no strobe.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scancode receiver.
//   ps2_ev_t    : one decoded key event {ext, rel, code}, 10 bits.
//                 The release flag is named rel because "release" is a
//                 SystemVerilog keyword.
//   ps2_state_t : frame FSM states.
//   Prefix constants and the odd-parity helper.
package ps2_pkg;

  typedef struct packed {
    logic       ext;   // E0-prefixed
    logic       rel;   // F0-prefixed (key release)
    logic [7:0] code;
  } ps2_ev_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL    = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam int         PS2_PAUSE_SKIP = 7;

  // Odd parity over data + parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_ev_fifo.sv
// ps2_ev_fifo: synchronous FIFO of ps2_ev_t with a valid/ready pop side.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_ev   : write request and data (dropped when full with no pop)
//   out_ready       : consumer accepts the head
//   out_valid       : head holds an event
//   out_ev          : head event, forced to 0 while empty
//   overflow        : one-cycle pulse when a push was dropped
module ps2_ev_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  ps2_ev_t push_ev,
  input  logic    out_ready,
  output logic    out_valid,
  output ps2_ev_t out_ev,
  output logic    overflow
);

  localparam int AW = $clog2(DEPTH);

  ps2_ev_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    cnt;
  logic           full, pop, do_push;

  assign out_valid = (cnt != '0);
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A pop frees the slot in the same cycle, so push-while-full succeeds then.
  assign do_push   = push && (!full || pop);
  assign out_ev    = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      cnt      <= cnt + (AW+1)'(do_push) - (AW+1)'(pop);
      overflow <= push && full && !pop;
    end
  end

  // Storage needs no reset: out_ev is masked until an entry is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ev;
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 receiver front end.
//   Synchronises and filters ps2_clk/ps2_dat, deserialises 11-bit frames,
//   checks stop bit and odd parity, folds E0/F0/E1 prefixes into complete
//   key events and queues them in ps2_ev_fifo.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ps2_clk, ps2_dat    : raw asynchronous PS/2 lines
//   ev_valid/ev_ready   : event handshake, ev_code/ev_ext/ev_release = head
//   err_parity          : pulse, frame dropped on parity error
//   err_frame           : pulse, bad stop bit or inter-bit timeout
//   overflow            : pulse, event dropped because FIFO full
// Build option: define PS2_RX_TIMEOUT_EN to abort frames that stall for
//   TIMEOUT_CYC cycles between clock edges; otherwise a partial frame
//   waits indefinitely.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);

  if (FILTER_LEN < 2 || FILTER_LEN > 15 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("ps2_scancode_rx: parameter out of range");
  end

  localparam int FW = $clog2(FILTER_LEN + 1);

  // ---------------- input conditioning ----------------
  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt, strobe, dat_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_flt  <= 1'b1;
      flt_cnt  <= '0;
      strobe   <= 1'b0;
      dat_s    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      strobe   <= 1'b0;
      // flt_cnt counts consecutive samples disagreeing with clk_flt; any
      // agreeing sample restarts it, so short glitches never flip the level.
      if (clk_sync[1] == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt <= '0;
        clk_flt <= clk_sync[1];
        strobe  <= clk_flt;        // only the 1->0 transition samples data
        dat_s   <= dat_sync[1];
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  // ---------------- frame FSM ----------------
  ps2_state_t state, nstate;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       par_bit;
  logic       tmo;
  logic       frame_ok, frame_perr, frame_ferr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (tmo) begin
      nstate = IDLE;
    end else if (strobe) begin
      unique case (state)
        IDLE:    if (!dat_s) nstate = DATA;
        DATA:    if (bit_cnt == 3'd7) nstate = PARITY;
        PARITY:  nstate = STOP;
        STOP:    nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok   = 1'b0;
    frame_perr = 1'b0;
    frame_ferr = tmo;
    if (strobe && state == STOP && !tmo) begin
      if (!dat_s)                             frame_ferr = 1'b1;
      else if (!ps2_parity_ok(shreg, par_bit)) frame_perr = 1'b1;
      else                                    frame_ok   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else if (strobe) begin
      case (state)
        IDLE:   bit_cnt <= '0;
        DATA: begin
          shreg   <= {dat_s, shreg[7:1]};   // LSB arrives first
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY: par_bit <= dat_s;
        default: ;
      endcase
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || strobe || tmo) tmo_cnt <= '0;
    else                                         tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  // ---------------- prefix folding ----------------
  logic       ext_f, rel_f;
  logic [2:0] skip;
  logic       push;
  ps2_ev_t    push_ev;

  always_comb begin
    push    = 1'b0;
    push_ev = '0;
    if (frame_ok) begin
      if (skip != '0) begin
        // Last byte of the 8-byte Pause sequence emits the synthetic event.
        if (skip == 3'd1) begin
          push    = 1'b1;
          push_ev = '{ext: 1'b1, rel: 1'b0, code: PS2_PAUSE_CODE};
        end
      end else if (shreg != PS2_PFX_EXT && shreg != PS2_PFX_REL &&
                   shreg != PS2_PFX_PAUSE) begin
        push    = 1'b1;
        push_ev = '{ext: ext_f, rel: rel_f, code: shreg};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_perr || frame_ferr) begin
      ext_f <= 1'b0;
      rel_f <= 1'b0;
      skip  <= '0;
    end else if (frame_ok) begin
      if (skip != '0)                skip  <= skip - 3'd1;
      else if (shreg == PS2_PFX_EXT) ext_f <= 1'b1;
      else if (shreg == PS2_PFX_REL) rel_f <= 1'b1;
      else if (shreg == PS2_PFX_PAUSE) skip <= 3'(PS2_PAUSE_SKIP);
      else begin
        ext_f <= 1'b0;
        rel_f <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      err_parity <= frame_perr;
      err_frame  <= frame_ferr;
    end
  end

  // ---------------- event FIFO ----------------
  ps2_ev_t head;

  ps2_ev_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_ev   (push_ev),
    .out_ready (ev_ready),
    .out_valid (ev_valid),
    .out_ev    (head),
    .overflow  (overflow)
  );

  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_release = head.rel;

endmodule
